hazard_stall_ctrl: RTL and testbench

- Hazard/stall controller for the 5-stage MIPS pipeline; it generates the hold and bubble enables that sequence the pipeline registers.
- Detects read-after-write hazards with Tuse/Tnew comparison over the EX and MEM stages.
- Owns a multi-cycle MDU busy counter (mult/div) and stalls HI/LO-dependent instructions in decode.
- Drives the PC hold, the IF/ID hold and the ID/EX bubble; the EX/MEM and MEM/WB registers always advance.

---
 rtl/hazard_stall_ctrl_pkg.sv | 29 ++
 rtl/hazard_stall_ctrl_md_busy_counter.sv | 45 ++++
 rtl/hazard_stall_ctrl.sv | 82 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// ============================================================================
// Module  : hazard_stall_ctrl_pkg
// Brief   : Shared constants and the RAW hazard compare for hazard_stall_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_stall_ctrl_pkg;

    localparam int          TNEW_W          = 2;
    localparam logic [1:0]  TUSE_NONE       = 2'd3;
    localparam logic [4:0]  REG_ZERO        = 5'd0;
    localparam int          MULT_CYCLES_DEF = 5;
    localparam int          DIV_CYCLES_DEF  = 10;

    // A producer blocks the consumer only when its result arrives later than
    // the consumer needs it. TUSE_NONE exceeds every legal tnew, so it never hits.
    function automatic logic raw_hit(
        input logic [4:0]        src,
        input logic [1:0]        tuse,
        input logic [4:0]        dst,
        input logic [TNEW_W-1:0] tnew
    );
        return (src != REG_ZERO) && (src == dst) && (tnew > tuse);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// ============================================================================
// Module  : md_busy_counter
// Brief   : Mult/div occupancy counter; a start is accepted only when idle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    logic [CNT_W-1:0] md_cnt;
    logic             cnt_idle;

    assign cnt_idle = (md_cnt == CNT_ZERO);

    // A start while the unit is occupied is dropped; the countdown carries on.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= CNT_ZERO;
        end else if (md_start && cnt_idle) begin
            md_cnt <= md_div ? DIV_LOAD : MULT_LOAD;
        end else if (!cnt_idle) begin
            md_cnt <= md_cnt - CNT_ONE;
        end
    end

    assign md_busy = md_start | ~cnt_idle;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module  : hazard_stall_ctrl
// Brief   : Pipeline hazard/stall controller (RAW Tuse/Tnew + MDU busy).
//           Optional macro STALL_PERF_EN adds a stall-cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        D_rs,
    input  logic [4:0]        D_rt,
    input  logic [1:0]        D_tuse_rs,
    input  logic [1:0]        D_tuse_rt,
    input  logic              D_is_md,
    input  logic [4:0]        E_RegAddr,
    input  logic [TNEW_W-1:0] E_tnew,
    input  logic [4:0]        M_RegAddr,
    input  logic [TNEW_W-1:0] M_tnew,
    input  logic              E_md_start,
    input  logic              E_md_div,
`ifdef STALL_PERF_EN
    input  logic              perf_clr,
    output logic [31:0]       stall_count,
`endif
    output logic              stall_PC,
    output logic              stall_D,
    output logic              flush_E,
    output logic              md_busy
);

    logic busy_int;
    logic stall_rs;
    logic stall_rt;
    logic md_stall;
    logic stall;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .md_start (E_md_start),
        .md_div   (E_md_div),
        .md_busy  (busy_int)
    );

    assign stall_rs = raw_hit(D_rs, D_tuse_rs, E_RegAddr, E_tnew)
                    | raw_hit(D_rs, D_tuse_rs, M_RegAddr, M_tnew);
    assign stall_rt = raw_hit(D_rt, D_tuse_rt, E_RegAddr, E_tnew)
                    | raw_hit(D_rt, D_tuse_rt, M_RegAddr, M_tnew);
    assign md_stall = D_is_md & busy_int;

    // Outputs stay quiet for the whole reset interval.
    assign stall    = ~reset & (stall_rs | stall_rt | md_stall);
    assign stall_PC = stall;
    assign stall_D  = stall;
    assign flush_E  = stall;
    assign md_busy  = ~reset & busy_int;

`ifdef STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            stall_count <= 32'd0;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module  : tb_hazard_stall_ctrl
// Brief   : Self-checking bench for hazard_stall_ctrl (STALL_PERF_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_RegAddr, M_RegAddr;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_div;
    logic       stall_PC, stall_D, flush_E, md_busy;
`ifdef STALL_PERF_EN
    logic        perf_clr;
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: absolute cycle index and the first cycle the MDU is free.
    int cyc     = 0;
    int free_at = 0;
    longint model_count = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_is_md    (D_is_md),
        .E_RegAddr  (E_RegAddr),
        .E_tnew     (E_tnew),
        .M_RegAddr  (M_RegAddr),
        .M_tnew     (M_tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
`ifdef STALL_PERF_EN
        .perf_clr   (perf_clr),
        .stall_count(stall_count),
`endif
        .stall_PC   (stall_PC),
        .stall_D    (stall_D),
        .flush_E    (flush_E),
        .md_busy    (md_busy)
    );

    function automatic logic model_busy();
        return !reset && (E_md_start || (cyc < free_at));
    endfunction

    function automatic logic model_stall();
        logic [4:0] srcs [2];
        logic [1:0] tuses[2];
        logic hit;
        srcs[0] = D_rs; srcs[1] = D_rt;
        tuses[0] = D_tuse_rs; tuses[1] = D_tuse_rt;
        hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (srcs[k] != 0) begin
                if (srcs[k] == E_RegAddr && int'(E_tnew) > int'(tuses[k])) hit = 1'b1;
                if (srcs[k] == M_RegAddr && int'(M_tnew) > int'(tuses[k])) hit = 1'b1;
            end
        end
        return !reset && (hit || (D_is_md && model_busy()));
    endfunction

    task automatic set_idle();
        reset = 1'b0;
        D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        D_is_md = 1'b0; E_RegAddr = 5'd0; E_tnew = 2'd0;
        M_RegAddr = 5'd0; M_tnew = 2'd0; E_md_start = 1'b0; E_md_div = 1'b0;
`ifdef STALL_PERF_EN
        perf_clr = 1'b0;
`endif
    endtask

    // Advance one clock and update the reference model from the sampled inputs.
    task automatic tick();
        logic st;
        st = model_stall();
        @(posedge clk);
        if (reset) free_at = 0;
        else if (E_md_start && !(cyc < free_at))
            free_at = cyc + (E_md_div ? DIV_N : MULT_N) + 1;
`ifdef STALL_PERF_EN
        if (reset || perf_clr) model_count = 0;
        else if (st) model_count = (model_count + 1) % 64'h1_0000_0000;
`endif
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1; E_md_start = 1'b1; D_is_md = 1'b1;
        D_rs = 5'd2; D_tuse_rs = 2'd0; E_RegAddr = 5'd2; E_tnew = 2'd2;
        #1;
        n_checks++;
        if ({stall_PC, stall_D, flush_E, md_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000", {stall_PC, stall_D, flush_E, md_busy});
        end
        tick(); tick();
        set_idle();
        #1;
        n_checks++;
        if ({stall_PC, md_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 00", {stall_PC, md_busy});
        end
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        E_RegAddr = 5'd1; E_tnew = 2'd2; D_rs = 5'd1; D_tuse_rs = 2'd1;
        #1;
        n_checks++;
        if ({stall_PC, stall_D, flush_E} !== 3'b111) begin
            n_fail++;
            $display("FAIL load_use_ex: got %b want 111", {stall_PC, stall_D, flush_E});
        end
        tick();
        E_RegAddr = 5'd0; E_tnew = 2'd0; M_RegAddr = 5'd1; M_tnew = 2'd1;
        #1;
        n_checks++;
        if ({stall_PC, stall_D, flush_E} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_use_mem: got %b want 000", {stall_PC, stall_D, flush_E});
        end
        tick();
        set_idle();
        M_RegAddr = 5'd7; M_tnew = 2'd1; D_rt = 5'd7; D_tuse_rt = 2'd0;
        #1;
        n_checks++;
        if (stall_D !== 1'b1) begin
            n_fail++;
            $display("FAIL rt_mem_hazard: got %b want 1", stall_D);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        set_idle();
        E_RegAddr = 5'd0; E_tnew = 2'd2; D_rs = 5'd0; D_tuse_rs = 2'd0;
        #1;
        n_checks++;
        if (stall_PC !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg: got %b want 0", stall_PC);
        end
        tick();
        E_RegAddr = 5'd5; E_tnew = 2'd2; D_rt = 5'd5; D_tuse_rt = 2'd3;
        #1;
        n_checks++;
        if (stall_PC !== 1'b0) begin
            n_fail++;
            $display("FAIL tuse_none: got %b want 0", stall_PC);
        end
        tick();
    endtask

    task automatic test_md(input logic is_div);
        int n;
        n = is_div ? DIV_N : MULT_N;
        set_idle();
        D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = is_div;
        for (int i = 0; i <= n + 1; i++) begin
            #1;
            n_checks++;
            if ({md_busy, stall_PC} !== {2{i <= n}}) begin
                n_fail++;
                $display("FAIL md_%s_c%0d: got %b want %b", is_div ? "div" : "mult", i,
                         {md_busy, stall_PC}, {2{i <= n}});
            end
            tick();
            E_md_start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        set_idle();
        E_md_start = 1'b1; D_is_md = 1'b0;
        #1;
        n_checks++;
        if ({md_busy, stall_PC} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_start: got %b want 10", {md_busy, stall_PC});
        end
        tick();
        E_md_start = 1'b0; D_is_md = 1'b1;
        for (int i = 1; i <= MULT_N + 1; i++) begin
            #1;
            n_checks++;
            if (stall_PC !== (i <= MULT_N)) begin
                n_fail++;
                $display("FAIL b2b_mfhi_c%0d: got %b want %b", i, stall_PC, i <= MULT_N);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_div();
        set_idle();
        D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b1;
        tick();
        E_md_start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({md_busy, stall_PC} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_t2: got %b want 00", {md_busy, stall_PC});
        end
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({md_busy, stall_PC} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_t3: got %b want 00", {md_busy, stall_PC});
        end
        tick();
    endtask

    task automatic test_random();
        logic exp_s, exp_b;
        set_idle();
        for (int i = 0; i < 300; i++) begin
            D_rs       = 5'($urandom_range(0, 3));
            D_rt       = 5'($urandom_range(0, 3));
            D_tuse_rs  = 2'($urandom_range(0, 3));
            D_tuse_rt  = 2'($urandom_range(0, 3));
            E_RegAddr  = 5'($urandom_range(0, 3));
            M_RegAddr  = 5'($urandom_range(0, 3));
            E_tnew     = 2'($urandom_range(0, 2));
            M_tnew     = 2'($urandom_range(0, 2));
            D_is_md    = 1'($urandom_range(0, 1));
            E_md_start = ($urandom_range(0, 7) == 0);
            E_md_div   = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 49) == 0);
`ifdef STALL_PERF_EN
            perf_clr   = ($urandom_range(0, 39) == 0);
`endif
            #1;
            exp_s = model_stall();
            exp_b = model_busy();
            n_checks++;
            if ({stall_PC, stall_D, flush_E, md_busy} !== {exp_s, exp_s, exp_s, exp_b}) begin
                n_fail++;
                $display("FAIL random_c%0d: got %b want %b", i,
                         {stall_PC, stall_D, flush_E, md_busy}, {exp_s, exp_s, exp_s, exp_b});
            end
`ifdef STALL_PERF_EN
            n_checks++;
            if (stall_count !== 32'(model_count)) begin
                n_fail++;
                $display("FAIL random_count_c%0d: got %0d want %0d", i, stall_count, model_count);
            end
`endif
            tick();
        end
        set_idle();
    endtask

`ifdef STALL_PERF_EN
    task automatic test_perf();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            E_RegAddr = 5'd1; E_tnew = 2'd2; D_rs = 5'd1; D_tuse_rs = 2'd1;
            tick();
            set_idle();
            tick();
        end
        D_is_md = 1'b1; E_md_start = 1'b1;
        tick();
        E_md_start = 1'b0;
        for (int i = 0; i < MULT_N + 1; i++) tick();
        #1;
        n_checks++;
        if (stall_count !== 32'd9) begin
            n_fail++;
            $display("FAIL perf_count: got %0d want 9", stall_count);
        end
        set_idle();
        E_RegAddr = 5'd3; E_tnew = 2'd2; D_rt = 5'd3; D_tuse_rt = 2'd0; perf_clr = 1'b1;
        tick();
        set_idle();
        #1;
        n_checks++;
        if (stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_clr: got %0d want 0", stall_count);
        end
        tick();
    endtask
`endif

    initial begin
        set_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_md(1'b0);
        test_md(1'b1);
        test_back_to_back();
        test_reset_mid_div();
`ifdef STALL_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
